core_loader: RTL and testbench
==============================

CORE_LOADER -- requirements
Module: core_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, instruction-memory depth in words; power of two, >= 2.
REQ-003 SHALL have parameter NUM_OUTPORTS, default 4, count of memory-mapped output registers; >= 1.
REQ-004 SHALL have ports, clock and reset first:
 clk  input  1  sole clock, rising edge
 rst  input  1  asynchronous reset, active-low
 load_req  input  1  request to start a program load
 flash_valid  input  1  flash beat valid
 flash_ready  output  1  loader accepts beat
 flash_addr  input  WIDTH  byte address of beat
 flash_data  input  WIDTH  instruction word
 flash_last  input  1  final beat of program
 mem_wren  output  1  instruction-memory write strobe
 mem_addr  output  $clog2(DEPTH)  word address
 mem_wdata  output  WIDTH  write data
 core_hold  output  1  holds core in reset/stall
 core_halt  input  1  core finished (e.g. ecall)
 io_wren  input  1  core store to outport space
 io_addr  input  WIDTH  outport index
 io_wdata  input  WIDTH  store data
 outport  output  NUM_OUTPORTS*WIDTH  flattened outport registers, port k at bits [k*WIDTH +: WIDTH]
 word_count  output  $clog2(DEPTH)+1  beats written this load
 fault  output  1  sticky load error
 state_o  output  2  current state code

Function
REQ-005 SHALL implement FSM states IDLE=0, LOAD=1, RUN=2, FAULT=3, reported on state_o.
REQ-006 IDLE: core_hold=1, flash_ready=0; load_req=1 -> LOAD next cycle, word_count cleared to 0 on that transition.
REQ-007 LOAD: core_hold=1, flash_ready=1; beat accepted when flash_valid && flash_ready.
REQ-008 Accepted beat is legal iff flash_addr[1:0]==0 and flash_addr>>2 < DEPTH.
REQ-009 Legal beat SHALL drive mem_wren=1, mem_addr=flash_addr>>2, mem_wdata=flash_data in the cycle after acceptance (latency 1, registered); word_count increments same cycle as mem_wren, saturating at DEPTH.
REQ-010 Illegal beat SHALL produce no write, set fault=1, and move to FAULT next cycle regardless of flash_last.
REQ-011 Legal beat with flash_last=1 -> RUN next cycle; the final write still occurs one cycle later per REQ-009.
REQ-012 RUN: core_hold=0 starting the cycle after the final mem_wren pulse (core never runs before its last write lands); flash_ready=0; load_req ignored.
REQ-013 RUN: io_wren=1 with io_addr < NUM_OUTPORTS SHALL write io_wdata to outport[io_addr] at that clock edge; out-of-range io_addr ignored; io_wren outside RUN ignored.
REQ-014 RUN: core_halt=1 -> IDLE next cycle; an io_wren in the same cycle is honoured.
REQ-015 FAULT: core_hold=1, flash_ready=0, fault=1; state exits only via reset; load_req ignored.
REQ-016 mem_wren SHALL be 0 in every cycle not following a legal accepted beat.
REQ-017 outport values SHALL persist across IDLE/LOAD/FAULT until overwritten or reset.
REQ-018 load_req in LOAD ignored; flash_valid outside LOAD ignored.

Reset
REQ-019 rst=0 SHALL asynchronously force state IDLE, core_hold=1, flash_ready=0, mem_wren=0, mem_addr=0, mem_wdata=0, word_count=0, fault=0, all outport words=0.
REQ-020 Reset asserted mid-LOAD SHALL discard any pending registered write (mem_wren=0 immediately).
REQ-021 After rst deasserts, first state change occurs no earlier than the first rising clk edge.

Verification
REQ-022 Load 3 beats addr 0x0,0x4,0x8 data 0x11,0x22,0x33, last on third -> mem writes at word 0,1,2 one cycle after each handshake, word_count=3, core_hold falls after third write.
REQ-023 In LOAD send flash_addr=0x6 -> no mem_wren, fault=1, state_o=3; subsequent load_req has no effect.
REQ-024 DEPTH=1024, flash_addr=0x1000 -> fault; flash_addr=0xFFC -> write to word 1023.
REQ-025 RUN, io_wren with io_addr=2 data 0xDEADBEEF -> outport bits [95:64]=0xDEADBEEF next edge; io_addr=4 (NUM_OUTPORTS=4) -> no change.
REQ-026 RUN, core_halt and io_wren (addr 0, 0x5) same cycle -> outport[0]=0x5, state IDLE, core_hold=1; then new load_req re-enters LOAD with word_count=0.
REQ-027 Assert rst during LOAD between handshake and write -> mem_wren stays 0, all outputs at reset values.

Source files
------------

// File: rtl/core_loader.sv
// core_loader: streams a program image from a flash beat interface into
// instruction memory, then releases the core and exposes a small bank of
// memory-mapped output registers that the running core can store to.
module core_loader #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 1024,
  parameter int NUM_OUTPORTS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_req,
  input  logic                          flash_valid,
  output logic                          flash_ready,
  input  logic [WIDTH-1:0]              flash_addr,
  input  logic [WIDTH-1:0]              flash_data,
  input  logic                          flash_last,
  output logic                          mem_wren,
  output logic [$clog2(DEPTH)-1:0]      mem_addr,
  output logic [WIDTH-1:0]              mem_wdata,
  output logic                          core_hold,
  input  logic                          core_halt,
  input  logic                          io_wren,
  input  logic [WIDTH-1:0]              io_addr,
  input  logic [WIDTH-1:0]              io_wdata,
  output logic [NUM_OUTPORTS*WIDTH-1:0] outport,
  output logic [$clog2(DEPTH):0]        word_count,
  output logic                          fault,
  output logic [1:0]                    state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              flashReady_q;
  logic              coreHold_q;
  logic              memWren_q;
  logic [AW-1:0]     memAddr_q;
  logic [WIDTH-1:0]  memWdata_q;
  logic [CW-1:0]     wordCount_q;
  logic              fault_q;
  logic [WIDTH-1:0]  outport_q [NUM_OUTPORTS];

  logic [WIDTH-1:0]  beatWord;
  logic              beatAccept;
  logic              beatLegal;

  // Classify the current flash beat and pick the next state.
  always_comb begin
    beatWord   = flash_addr >> 2;
    beatAccept = (state_q == LOAD) && flash_valid && flashReady_q;
    beatLegal  = (flash_addr[1:0] == 2'b00) && (beatWord < WIDTH'(DEPTH));
    state_d    = state_q;
    case (state_q)
      IDLE:    if (load_req) state_d = LOAD;
      LOAD: begin
        if (beatAccept) begin
          if (!beatLegal)      state_d = FAULT;
          else if (flash_last) state_d = RUN;
        end
      end
      RUN:     if (core_halt) state_d = IDLE;
      default: state_d = state_q;
    endcase
  end

  // Loader FSM with registered handshake, memory-write and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      flashReady_q <= 1'b0;
      coreHold_q   <= 1'b1;
      memWren_q    <= 1'b0;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      wordCount_q  <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      flashReady_q <= (state_d == LOAD);
      // The core is released only after one full RUN cycle, so the final
      // write (issued in the first RUN cycle) has landed before it fetches.
      coreHold_q   <= !((state_q == RUN) && (state_d == RUN));
      memWren_q    <= beatAccept && beatLegal;
      if (beatAccept && beatLegal) begin
        memAddr_q  <= beatWord[AW-1:0];
        memWdata_q <= flash_data;
        if (wordCount_q != CW'(DEPTH)) begin
          wordCount_q <= wordCount_q + CW'(1);
        end
      end
      if ((state_q == IDLE) && load_req) begin
        wordCount_q <= '0;
      end
      if (beatAccept && !beatLegal) begin
        fault_q <= 1'b1;
      end
    end
  end

  // Output register bank, writable by the core only while it is running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_OUTPORTS; k++) begin
        outport_q[k] <= '0;
      end
    end else if ((state_q == RUN) && io_wren) begin
      for (int k = 0; k < NUM_OUTPORTS; k++) begin
        if (io_addr == WIDTH'(k)) begin
          outport_q[k] <= io_wdata;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OUTPORTS; g++) begin : gOutport
    assign outport[g*WIDTH +: WIDTH] = outport_q[g];
  end

  assign flash_ready = flashReady_q;
  assign core_hold   = coreHold_q;
  assign mem_wren    = memWren_q;
  assign mem_addr    = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign word_count  = wordCount_q;
  assign fault       = fault_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_core_loader.sv
// Testbench for core_loader: table-driven load and outport vectors, a
// scoreboard queue for instruction-memory writes, and hand-written
// sequences for faults, reset corner cases and word-count saturation.
module tb_core_loader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int NP    = 4;
  localparam int AW    = 10;

  logic              clk;
  logic              rst;
  logic              load_req;
  logic              flash_valid;
  logic              flash_ready;
  logic [WIDTH-1:0]  flash_addr;
  logic [WIDTH-1:0]  flash_data;
  logic              flash_last;
  logic              mem_wren;
  logic [AW-1:0]     mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              core_hold;
  logic              core_halt;
  logic              io_wren;
  logic [WIDTH-1:0]  io_addr;
  logic [WIDTH-1:0]  io_wdata;
  logic [NP*WIDTH-1:0] outport;
  logic [AW:0]       word_count;
  logic              fault;
  logic [1:0]        state_o;

  core_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_OUTPORTS(NP)) dut (
    .clk(clk), .rst(rst), .load_req(load_req),
    .flash_valid(flash_valid), .flash_ready(flash_ready),
    .flash_addr(flash_addr), .flash_data(flash_data), .flash_last(flash_last),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .core_halt(core_halt),
    .io_wren(io_wren), .io_addr(io_addr), .io_wdata(io_wdata),
    .outport(outport), .word_count(word_count), .fault(fault), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int               cyc;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_t;
  wr_t sbq[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
    bit          wr;
    logic [1:0]  expState;
    logic [10:0] expCount;
    bit          expHold;
  } beat_t;

  typedef struct {
    logic [31:0]  addr;
    logic [31:0]  data;
    logic [127:0] expOut;
  } io_t;

  beat_t loadTab[3];
  io_t   ioTab[5];

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: each expected write must appear exactly one cycle
  // after its handshake edge, and no other write may appear.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        checkOutput("mem_write_missed", 128'(e.addr), 128'(AW'('1)) ^ 128'(e.addr) ^ 128'(AW'('1)) + 128'h1_0000_0000);
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        checkOutput("mem_wren", 128'(mem_wren), 128'(1));
        checkOutput("mem_addr", 128'(mem_addr), 128'(e.addr));
        checkOutput("mem_wdata", 128'(mem_wdata), 128'(e.data));
      end else if (mem_wren) begin
        checkOutput("mem_wren_spurious", 128'(mem_wren), 128'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one flash beat for one cycle; push the expected write if legal.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input bit last, input bit wr);
    wr_t e;
    @(negedge clk);
    flash_valid = 1'b1;
    flash_addr  = addr;
    flash_data  = data;
    flash_last  = last;
    if (wr) begin
      e.cyc  = cyc + 1;
      e.addr = addr[AW+1:2];
      e.data = data;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    flash_valid = 1'b0;
    flash_last  = 1'b0;
  endtask

  task automatic pulseLoadReq();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  task automatic ioWrite(input logic [31:0] addr, input logic [31:0] data, input bit halt);
    @(negedge clk);
    io_wren   = 1'b1;
    io_addr   = addr;
    io_wdata  = data;
    core_halt = halt;
    @(posedge clk);
    #1;
    io_wren   = 1'b0;
    core_halt = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_state"},     128'(state_o),     128'(0));
    checkOutput({tag, "_hold"},      128'(core_hold),   128'(1));
    checkOutput({tag, "_ready"},     128'(flash_ready), 128'(0));
    checkOutput({tag, "_wren"},      128'(mem_wren),    128'(0));
    checkOutput({tag, "_maddr"},     128'(mem_addr),    128'(0));
    checkOutput({tag, "_mwdata"},    128'(mem_wdata),   128'(0));
    checkOutput({tag, "_count"},     128'(word_count),  128'(0));
    checkOutput({tag, "_fault"},     128'(fault),       128'(0));
    checkOutput({tag, "_outport"},   128'(outport),     128'(0));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    sbq.delete();
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    loadTab[0] = '{addr: 32'h0, data: 32'h11, last: 1'b0, wr: 1'b1, expState: 2'd1, expCount: 11'd1, expHold: 1'b1};
    loadTab[1] = '{addr: 32'h4, data: 32'h22, last: 1'b0, wr: 1'b1, expState: 2'd1, expCount: 11'd2, expHold: 1'b1};
    loadTab[2] = '{addr: 32'h8, data: 32'h33, last: 1'b1, wr: 1'b1, expState: 2'd2, expCount: 11'd3, expHold: 1'b1};

    ioTab[0] = '{addr: 32'd2,     data: 32'hDEADBEEF, expOut: 128'h00000000_DEADBEEF_00000000_00000000};
    ioTab[1] = '{addr: 32'd4,     data: 32'h12345678, expOut: 128'h00000000_DEADBEEF_00000000_00000000};
    ioTab[2] = '{addr: 32'd0,     data: 32'hA5A5A5A5, expOut: 128'h00000000_DEADBEEF_00000000_A5A5A5A5};
    ioTab[3] = '{addr: 32'd3,     data: 32'h0BADF00D, expOut: 128'h0BADF00D_DEADBEEF_00000000_A5A5A5A5};
    ioTab[4] = '{addr: 32'h102,   data: 32'hCAFEF00D, expOut: 128'h0BADF00D_DEADBEEF_00000000_A5A5A5A5};

    rst = 1'b0; load_req = 1'b0; flash_valid = 1'b0; flash_addr = '0; flash_data = '0;
    flash_last = 1'b0; core_halt = 1'b0; io_wren = 1'b0; io_addr = '0; io_wdata = '0;
    repeat (2) @(negedge clk);
    checkResetState("por");
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_after_release", 128'(state_o), 128'(0));

    // Flash beats outside LOAD are ignored.
    applyStimulus(32'h0, 32'h99, 1'b0, 1'b0);
    checkOutput("idle_flash_ignored_state", 128'(state_o), 128'(0));
    checkOutput("idle_flash_ignored_count", 128'(word_count), 128'(0));

    pulseLoadReq();
    checkOutput("enter_load_state", 128'(state_o), 128'(1));
    checkOutput("enter_load_ready", 128'(flash_ready), 128'(1));
    checkOutput("enter_load_count", 128'(word_count), 128'(0));

    for (int i = 0; i < 3; i++) begin
      applyStimulus(loadTab[i].addr, loadTab[i].data, loadTab[i].last, loadTab[i].wr);
      checkOutput($sformatf("load%0d_state", i), 128'(state_o), 128'(loadTab[i].expState));
      checkOutput($sformatf("load%0d_count", i), 128'(word_count), 128'(loadTab[i].expCount));
      checkOutput($sformatf("load%0d_hold", i), 128'(core_hold), 128'(loadTab[i].expHold));
    end
    @(posedge clk);
    #1;
    checkOutput("run_hold_released", 128'(core_hold), 128'(0));
    checkOutput("run_ready_low", 128'(flash_ready), 128'(0));

    pulseLoadReq();
    checkOutput("run_loadreq_ignored", 128'(state_o), 128'(2));
    checkOutput("run_count_kept", 128'(word_count), 128'(3));

    for (int i = 0; i < 5; i++) begin
      ioWrite(ioTab[i].addr, ioTab[i].data, 1'b0);
      checkOutput($sformatf("io%0d_outport", i), 128'(outport), ioTab[i].expOut);
    end

    ioWrite(32'd0, 32'h5, 1'b1);
    checkOutput("halt_io_outport", 128'(outport), 128'h0BADF00D_DEADBEEF_00000000_00000005);
    checkOutput("halt_state", 128'(state_o), 128'(0));
    checkOutput("halt_hold", 128'(core_hold), 128'(1));

    ioWrite(32'd1, 32'h77, 1'b0);
    checkOutput("idle_io_ignored", 128'(outport), 128'h0BADF00D_DEADBEEF_00000000_00000005);

    pulseLoadReq();
    checkOutput("reload_state", 128'(state_o), 128'(1));
    checkOutput("reload_count", 128'(word_count), 128'(0));

    applyStimulus(32'hFFC, 32'hABCD0001, 1'b0, 1'b1);
    checkOutput("top_word_count", 128'(word_count), 128'(1));
    checkOutput("top_word_state", 128'(state_o), 128'(1));

    applyStimulus(32'h1000, 32'hBAD, 1'b0, 1'b0);
    checkOutput("oob_state", 128'(state_o), 128'(3));
    checkOutput("oob_fault", 128'(fault), 128'(1));
    checkOutput("oob_count", 128'(word_count), 128'(1));
    checkOutput("oob_ready", 128'(flash_ready), 128'(0));
    checkOutput("oob_hold", 128'(core_hold), 128'(1));

    pulseLoadReq();
    checkOutput("fault_loadreq_ignored", 128'(state_o), 128'(3));
    applyStimulus(32'h0, 32'h1, 1'b1, 1'b0);
    checkOutput("fault_flash_ignored", 128'(state_o), 128'(3));
    checkOutput("fault_outport_persist", 128'(outport), 128'h0BADF00D_DEADBEEF_00000000_00000005);

    doReset();

    // Misaligned beat faults even when marked last.
    pulseLoadReq();
    applyStimulus(32'h6, 32'h66, 1'b1, 1'b0);
    checkOutput("misalign_state", 128'(state_o), 128'(3));
    checkOutput("misalign_fault", 128'(fault), 128'(1));
    checkOutput("misalign_count", 128'(word_count), 128'(0));
    pulseLoadReq();
    checkOutput("misalign_loadreq_ignored", 128'(state_o), 128'(3));

    doReset();

    // Reset while a beat is being handed over: no write may come out.
    pulseLoadReq();
    @(negedge clk);
    flash_valid = 1'b1;
    flash_addr  = 32'h10;
    flash_data  = 32'h1234;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_hs_wren", 128'(mem_wren), 128'(0));
    @(posedge clk);
    #1;
    flash_valid = 1'b0;
    checkResetState("rst_mid_hs");
    @(negedge clk);
    rst = 1'b1;

    // Reset right after an accepted beat kills the registered write.
    pulseLoadReq();
    applyStimulus(32'h20, 32'h55, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    sbq.delete();
    checkOutput("rst_after_accept_wren", 128'(mem_wren), 128'(0));
    checkResetState("rst_after_accept");
    @(negedge clk);
    rst = 1'b1;

    // More beats than DEPTH: word_count saturates at DEPTH.
    pulseLoadReq();
    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus(32'(i % DEPTH) << 2, 32'(i), (i == DEPTH), 1'b1);
    end
    checkOutput("sat_count", 128'(word_count), 128'(DEPTH));
    checkOutput("sat_state", 128'(state_o), 128'(2));

    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 128'(sbq.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
